// File: rtl/mch3d_pkg.sv
// Shared definitions for the QPI framebuffer reader and its LCD-side consumers.
package mch3d_pkg;

    localparam logic [7:0] QPI_CMD_FAST_READ = 8'h0B;
    localparam int ADDR_W             = 24;
    localparam int DEF_LEN_W          = 18;
    localparam int DEF_DUMMY_CYCLES   = 5;
    localparam int DEF_MAX_BURST      = 1024;
    localparam int DEF_CS_HIGH_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_GAP
    } qfr_state_t;

endpackage

// File: rtl/qspi_frame_reader_if.sv
// Control, byte-stream and QPI pin bundle of the framebuffer reader.
interface qspi_frame_reader_if #(
    parameter int LEN_W = mch3d_pkg::DEF_LEN_W
);
    logic                          start;
    logic [mch3d_pkg::ADDR_W-1:0]  start_addr;
    logic [LEN_W-1:0]              byte_count;
    logic                          busy;
    logic                          done;
    logic [7:0]                    out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          ram_clk;
    logic                          ram_cs_n;
    logic [3:0]                    ram_io_o;
    logic                          ram_io_oe;
    logic [3:0]                    ram_io_i;

    modport master (
        output start, start_addr, byte_count, out_ready, ram_io_i,
        input  busy, done, out_data, out_valid, ram_clk, ram_cs_n, ram_io_o, ram_io_oe
    );

    modport slave (
        input  start, start_addr, byte_count, out_ready, ram_io_i,
        output busy, done, out_data, out_valid, ram_clk, ram_cs_n, ram_io_o, ram_io_oe
    );
endinterface

// File: rtl/byte_fifo4.sv
// 4-entry byte FIFO with occupancy output; the head entry is presented from registers.
module byte_fifo4 (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic [2:0] o_count
);
    logic [7:0] r_mem [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 3'd0);
    assign w_do_push = i_push && (r_count != 3'd4);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
            r_wp    <= 2'd0;
            r_rp    <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_do_pop) r_rp <= r_rp + 2'd1;
            r_count <= r_count + {2'd0, w_do_push} - {2'd0, w_do_pop};
        end
    end

    assign o_data  = r_mem[r_rp];
    assign o_valid = (r_count != 3'd0);
    assign o_count = r_count;
endmodule

// File: rtl/qspi_frame_reader.sv
// QPI PSRAM Fast Read engine: streams a contiguous byte region out, splitting it into
// CS-low bursts on MAX_BURST or when the output FIFO nears full.
//   IDLE  | waiting for start
//   CMD   | CS low, command nibbles 0x0, 0xB
//   ADDR  | six address nibbles, MSB first
//   DUMMY | turnaround clocks, bus released
//   READ  | sampling data nibbles into bytes
//   GAP   | CS high between bursts, or draining before done
module qspi_frame_reader
    import mch3d_pkg::*;
#(
    parameter int LEN_W          = DEF_LEN_W,
    parameter int DUMMY_CYCLES   = DEF_DUMMY_CYCLES,
    parameter int MAX_BURST      = DEF_MAX_BURST,
    parameter int CS_HIGH_CYCLES = DEF_CS_HIGH_CYCLES
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    qspi_frame_reader_if.slave   bus
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    qfr_state_t        r_state;
    logic              r_ram_clk;
    logic              r_cs_n;
    logic [3:0]        r_io_o;
    logic              r_io_oe;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic [BW-1:0]     r_bcnt;
    logic [7:0]        r_tmr;
    logic [27:0]       r_sh;
    logic [3:0]        r_hi;
    logic              r_lo;

    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [7:0]        w_byte;
    logic [7:0]        w_data;
    logic [2:0]        w_fifo_cnt;
    logic [3:0]        w_cnt_after;
    logic              w_end_burst;

    assign w_pop       = w_valid && bus.out_ready;
    assign w_push      = (r_state == ST_READ) && r_ram_clk && r_lo;
    assign w_byte      = {r_hi, bus.ram_io_i};
    assign w_cnt_after = {1'b0, w_fifo_cnt} + 4'd1 - {3'd0, w_pop};
    // Stop at a byte boundary while at least one FIFO slot is still free after this push.
    assign w_end_burst = (r_rem == LEN_W'(1)) || (r_bcnt == BW'(MAX_BURST - 1)) ||
                         (w_cnt_after >= 4'd3);

    byte_fifo4 u_fifo (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_byte),
        .i_pop   (w_pop),
        .o_data  (w_data),
        .o_valid (w_valid),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ram_clk <= 1'b0;
            r_cs_n    <= 1'b1;
            r_io_o    <= 4'h0;
            r_io_oe   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_bcnt    <= '0;
            r_tmr     <= 8'd0;
            r_sh      <= '0;
            r_hi      <= 4'h0;
            r_lo      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.byte_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_CMD;
                            r_busy  <= 1'b1;
                            r_addr  <= bus.start_addr;
                            r_rem   <= bus.byte_count;
                        end
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_READ: begin
                    if (r_cs_n) begin
                        r_cs_n  <= 1'b0;
                        r_io_oe <= 1'b1;
                        r_io_o  <= QPI_CMD_FAST_READ[7:4];
                        r_sh    <= {QPI_CMD_FAST_READ[3:0], r_addr};
                        r_tmr   <= 8'd1;
                        r_bcnt  <= '0;
                        r_lo    <= 1'b0;
                    end else if (!r_ram_clk) begin
                        r_ram_clk <= 1'b1;
                    end else begin
                        // Falling edge: RAM data is sampled here, next nibble is launched.
                        r_ram_clk <= 1'b0;
                        r_io_o    <= r_sh[27:24];
                        r_sh      <= {r_sh[23:0], 4'h0};
                        r_tmr     <= r_tmr - 8'd1;
                        case (r_state)
                            ST_CMD: begin
                                if (r_tmr == 8'd0) begin
                                    r_state <= ST_ADDR;
                                    r_tmr   <= 8'd5;
                                end
                            end
                            ST_ADDR: begin
                                if (r_tmr == 8'd0) begin
                                    r_io_oe <= 1'b0;
                                    if (DUMMY_CYCLES == 0) begin
                                        r_state <= ST_READ;
                                    end else begin
                                        r_state <= ST_DUMMY;
                                        r_tmr   <= 8'(DUMMY_CYCLES - 1);
                                    end
                                end
                            end
                            ST_DUMMY: begin
                                if (r_tmr == 8'd0) r_state <= ST_READ;
                            end
                            default: begin
                                if (!r_lo) begin
                                    r_hi <= bus.ram_io_i;
                                    r_lo <= 1'b1;
                                end else begin
                                    r_lo   <= 1'b0;
                                    r_addr <= r_addr + ADDR_W'(1);
                                    r_rem  <= r_rem - LEN_W'(1);
                                    r_bcnt <= r_bcnt + BW'(1);
                                    if (w_end_burst) begin
                                        r_state <= ST_GAP;
                                        r_cs_n  <= 1'b1;
                                        r_tmr   <= 8'(CS_HIGH_CYCLES - 1);
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_GAP: begin
                    if (r_tmr != 8'd0) begin
                        r_tmr <= r_tmr - 8'd1;
                    end else if (r_rem == '0) begin
                        if (w_fifo_cnt == 3'd0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_fifo_cnt <= 3'd1) begin
                        r_state <= ST_CMD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_data  = w_data;
    assign bus.out_valid = w_valid;
    assign bus.ram_clk   = r_ram_clk;
    assign bus.ram_cs_n  = r_cs_n;
    assign bus.ram_io_o  = r_io_o;
    assign bus.ram_io_oe = r_io_oe;
endmodule
